// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and width constants for the ALU request scheduler.
package alu_pkg;
   localparam logic [3:0] ADD     = 4'd0;
   localparam logic [3:0] SUB     = 4'd1;
   localparam logic [3:0] MUL     = 4'd2;
   localparam logic [3:0] ROR     = 4'd3;
   localparam logic [3:0] NOR     = 4'd4;
   localparam logic [3:0] SLT     = 4'd5;
   localparam logic [3:0] IDLE_OP = 4'hF;

   localparam int CARRY = 3;
   localparam int ZERO  = 2;
   localparam int OVF   = 1;
   localparam int SIGN  = 0;

   localparam int DEFAULT_WIDTH = 16;
   localparam int SHIFT_W       = 5;
endpackage

// File: rtl/alu_rsp_fifo.sv
// First-word fall-through synchronous FIFO holding {id, result, flags} responses.
module alu_rsp_fifo #(
   parameter int DW    = 21,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          empty, full, do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty;
   // A push into a full FIFO is fine when the head leaves on the same edge.
   assign do_push = push_i && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
         if (do_pop)  rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign valid_o = !empty;
   assign data_o  = empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one pipelined ALU between NUM_REQ requesters, with id-tagged
// in-order responses and credit flow control against the response FIFO.
module alu_rr_scheduler
   import alu_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int NUM_REQ    = 2,
   parameter int ALU_LAT    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*4-1:0]         req_opcode,
   input  logic [NUM_REQ*WIDTH-1:0]     req_a,
   input  logic [NUM_REQ*WIDTH-1:0]     req_b,
   input  logic [NUM_REQ*SHIFT_W-1:0]   req_shift,
   output logic [3:0]                   alu_opcode,
   output logic [WIDTH-1:0]             alu_input1,
   output logic [WIDTH-1:0]             alu_input2,
   output logic [SHIFT_W-1:0]           alu_shiftValue,
   input  logic [WIDTH-1:0]             alu_result,
   input  logic [3:0]                   alu_flags,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]             rsp_result,
   output logic [3:0]                   rsp_flags
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int RSP_W = ID_W + WIDTH + 4;

   logic [ID_W-1:0]  ptr_q, ptr_d, winner;
   logic [ID_W:0]    idx;
   logic             any_valid, credit_ok, hs, pop;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [ALU_LAT-1:0] tag_vld_q;
   logic [ID_W-1:0]  tag_id_q [ALU_LAT];
   logic [RSP_W-1:0] fifo_dout;

   // Scan offsets from far to near so the requester closest to the pointer wins.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr_q} + (ID_W + 1)'(k);
         if (idx >= (ID_W + 1)'(NUM_REQ)) idx = idx - (ID_W + 1)'(NUM_REQ);
         if (req_valid[idx[ID_W-1:0]]) begin
            winner    = idx[ID_W-1:0];
            any_valid = 1'b1;
         end
      end
   end

   assign credit_ok = (outstanding_q < CNT_W'(FIFO_DEPTH));

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = !rst && any_valid && credit_ok && (winner == ID_W'(gi));
   end

   assign hs    = |(req_valid & req_ready);
   assign pop   = rsp_valid && rsp_ready;
   assign ptr_d = !hs ? ptr_q :
                  (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

   always_comb begin
      case ({hs, pop})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q          <= '0;
         outstanding_q  <= '0;
         alu_opcode     <= IDLE_OP;
         alu_input1     <= '0;
         alu_input2     <= '0;
         alu_shiftValue <= '0;
         tag_vld_q      <= '0;
         for (int k = 0; k < ALU_LAT; k++) tag_id_q[k] <= '0;
      end else begin
         ptr_q         <= ptr_d;
         outstanding_q <= outstanding_d;
         alu_opcode    <= hs ? req_opcode[int'(winner)*4 +: 4] : IDLE_OP;
         if (hs) begin
            alu_input1     <= req_a[int'(winner)*WIDTH +: WIDTH];
            alu_input2     <= req_b[int'(winner)*WIDTH +: WIDTH];
            alu_shiftValue <= req_shift[int'(winner)*SHIFT_W +: SHIFT_W];
         end
         // Stage 0 lines up with the issue register; the last stage lines up with alu_result.
         tag_vld_q[0] <= hs;
         tag_id_q[0]  <= winner;
         for (int k = 1; k < ALU_LAT; k++) begin
            tag_vld_q[k] <= tag_vld_q[k-1];
            tag_id_q[k]  <= tag_id_q[k-1];
         end
      end
   end

   alu_rsp_fifo #(
      .DW    (RSP_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (tag_vld_q[ALU_LAT-1]),
      .push_data_i ({tag_id_q[ALU_LAT-1], alu_result, alu_flags}),
      .pop_i       (pop),
      .valid_o     (rsp_valid),
      .data_o      (fifo_dout)
   );

   assign {rsp_id, rsp_result, rsp_flags} = fifo_dout;
endmodule
